// File: rtl/deserializer.sv
// Serial-to-parallel converter: gathers DATA_W qualified serial bits into one
// parallel word and strobes deser_data_val_o for one cycle per completed word.
// Bit order is MSB-first unless DESERIALIZER_LSB_FIRST_EN is defined, in which
// case the first received bit lands in deser_data_o[0].
module deserializer #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              data_i,
   input  logic              data_val_i,
   output logic [DATA_W-1:0] deser_data_o,
   output logic              deser_data_val_o
);

   localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int unsigned SHIFT_W = DATA_W - 1;

   // Only DATA_W-1 bits of history are kept; the final bit is merged straight
   // into the output word on the completing edge.
   logic [CNT_W-1:0]   r_cnt;
   logic [SHIFT_W-1:0] r_shift;
   logic [DATA_W-1:0]  r_data;
   logic               r_data_val;

   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [SHIFT_W-1:0] w_shift_nxt;
   logic [DATA_W-1:0]  w_word;
   logic [DATA_W-1:0]  w_data_nxt;
   logic               w_data_val_nxt;
   logic               w_last_bit;

   // Candidate word formed by merging the incoming bit with the history.
   always_comb begin
      w_word = '0;
`ifdef DESERIALIZER_LSB_FIRST_EN
      w_word = {data_i, r_shift};
`else
      w_word = {r_shift, data_i};
`endif
   end

   // Next-state for counter, history, output word and strobe.
   always_comb begin
      w_cnt_nxt      = r_cnt;
      w_shift_nxt    = r_shift;
      w_data_nxt     = r_data;
      w_data_val_nxt = 1'b0;
      w_last_bit     = (r_cnt == CNT_W'(DATA_W - 1));

      if (data_val_i) begin
`ifdef DESERIALIZER_LSB_FIRST_EN
         w_shift_nxt = w_word[DATA_W-1:1];
`else
         w_shift_nxt = w_word[DATA_W-2:0];
`endif
         if (w_last_bit) begin
            w_cnt_nxt      = '0;
            w_data_nxt     = w_word;
            w_data_val_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end
   end

   // State registers with synchronous reset taking priority over input.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_cnt      <= '0;
         r_shift    <= '0;
         r_data     <= '0;
         r_data_val <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_data     <= w_data_nxt;
         r_data_val <= w_data_val_nxt;
      end
   end

   assign deser_data_o     = r_data;
   assign deser_data_val_o = r_data_val;

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer (DATA_W = 16).
module tb_deserializer;

   localparam int unsigned DATA_W = 16;

   logic              clk;
   logic              srst;
   logic              din;
   logic              dval;
   logic [DATA_W-1:0] dout;
   logic              dout_val;

   int checks   = 0;
   int failures = 0;

   deserializer #(.DATA_W(DATA_W)) dut (
      .clk_i            (clk),
      .srst_i           (srst),
      .data_i           (din),
      .data_val_i       (dval),
      .deser_data_o     (dout),
      .deser_data_val_o (dout_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs for one clock, then settle 1 time unit past the edge.
   task automatic cyc(input logic d, input logic v, input logic r);
      din  = d;
      dval = v;
      srst = r;
      @(posedge clk);
      #1;
   endtask

   // Bit i (0 = first transmitted) of a word in the build's bit order.
   function automatic logic tx_bit(input logic [DATA_W-1:0] w, input int i);
`ifdef DESERIALIZER_LSB_FIRST_EN
      return w[i];
`else
      return w[DATA_W-1-i];
`endif
   endfunction

   task automatic do_reset();
      cyc(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      int strobes;
      cyc(1'b1, 1'b1, 1'b1);
      checks++;
      if (dout !== 16'h0000) begin
         failures++;
         $display("FAIL reset_data: got %h expected 0000", dout);
      end
      checks++;
      if (dout_val !== 1'b0) begin
         failures++;
         $display("FAIL reset_val: got %b expected 0", dout_val);
      end
      strobes = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         if (dout_val !== 1'b0) strobes++;
      end
      checks++;
      if (strobes != 0) begin
         failures++;
         $display("FAIL reset_no_strobe_15: got %0d strobes expected 0", strobes);
      end
   endtask

   task automatic test_gapped();
      logic [1:0] pat [24];
      logic [DATA_W-1:0] exp_w;
      pat = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10,
              2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b11, 2'b01, 2'b10,
              2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b01, 2'b11};
`ifdef DESERIALIZER_LSB_FIRST_EN
      exp_w = 16'hA2AA;
`else
      exp_w = 16'h5545;
`endif
      do_reset();
      for (int i = 0; i < 24; i++) begin
         cyc(pat[i][1], pat[i][0], 1'b0);
         checks++;
         if (dout_val !== (i == 23)) begin
            failures++;
            $display("FAIL gapped_val cycle %0d: got %b expected %b", i, dout_val, (i == 23));
         end
      end
      checks++;
      if (dout !== exp_w) begin
         failures++;
         $display("FAIL gapped_word: got %h expected %h", dout, exp_w);
      end
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] w [2];
      int strobe_at [2];
      int n;
      w = '{16'hA5C3, 16'h0FF0};
      strobe_at = '{-1, -1};
      n = 0;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         cyc(tx_bit(w[i / 16], i % 16), 1'b1, 1'b0);
         if (dout_val === 1'b1) begin
            if (n < 2) begin
               strobe_at[n] = i;
               checks++;
               if (dout !== w[n]) begin
                  failures++;
                  $display("FAIL b2b_word%0d: got %h expected %h", n, dout, w[n]);
               end
            end
            n++;
         end
      end
      checks++;
      if (n != 2) begin
         failures++;
         $display("FAIL b2b_count: got %0d strobes expected 2", n);
      end
      checks++;
      if (strobe_at[0] != 15 || strobe_at[1] != 31) begin
         failures++;
         $display("FAIL b2b_timing: got %0d,%0d expected 15,31", strobe_at[0], strobe_at[1]);
      end
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (dout_val !== 1'b0 || dout !== 16'h0FF0) begin
         failures++;
         $display("FAIL b2b_after: got val=%b data=%h expected 0 0ff0", dout_val, dout);
      end
   endtask

   task automatic test_hold();
      int bad;
      do_reset();
      for (int i = 0; i < 16; i++) cyc(tx_bit(16'h1234, i), 1'b1, 1'b0);
      checks++;
      if (dout_val !== 1'b1 || dout !== 16'h1234) begin
         failures++;
         $display("FAIL hold_word: got val=%b data=%h expected 1 1234", dout_val, dout);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'bx, 1'b0, 1'b0);
         if (dout !== 16'h1234 || dout_val !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold_idle: got %0d bad cycles expected 0 (data=%h)", bad, dout);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      int at;
      do_reset();
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      n  = 0;
      at = -1;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         if (dout_val === 1'b1) begin
            n++;
            at = i;
         end
      end
      checks++;
      if (n != 1 || at != 15) begin
         failures++;
         $display("FAIL midreset_strobe: got %0d strobes last at %0d expected 1 at 15", n, at);
      end
      checks++;
      if (dout !== 16'hFFFF) begin
         failures++;
         $display("FAIL midreset_word: got %h expected ffff", dout);
      end
   endtask

   task automatic test_reset_precedence();
      do_reset();
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      checks++;
      if (dout_val !== 1'b0) begin
         failures++;
         $display("FAIL prec_val: got %b expected 0", dout_val);
      end
      checks++;
      if (dout !== 16'h0000) begin
         failures++;
         $display("FAIL prec_data: got %h expected 0000", dout);
      end
      cyc(1'b1, 1'b1, 1'b0);
      checks++;
      if (dout_val !== 1'b0) begin
         failures++;
         $display("FAIL prec_next: got %b expected 0", dout_val);
      end
   endtask

   initial begin
      din  = 1'b0;
      dval = 1'b0;
      srst = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_gapped();
      test_back_to_back();
      test_hold();
      test_mid_reset();
      test_reset_precedence();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
